// File: rtl/core_pkg.sv
// Shared RV32I definitions for the pipeline stages: widths, opcodes and the
// control bundle carried from decode into execute.
package core_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic RegWrite;
    logic MemRead;
    logic MemWrite;
    logic Branch;
    logic Jump;
  } ctrl_t;

  // Unrecognised opcodes decode to an all-zero bundle; writes to x0 are dropped.
  function automatic ctrl_t decode_ctrl(input logic [6:0] opcode,
                                        input logic [REG_ADDR_W-1:0] rd);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_R, OP_IMM, OP_LUI: c.RegWrite = 1'b1;
      OP_LOAD: begin
        c.RegWrite = 1'b1;
        c.MemRead  = 1'b1;
      end
      OP_STORE:  c.MemWrite = 1'b1;
      OP_BRANCH: c.Branch   = 1'b1;
      OP_JAL, OP_JALR: begin
        c.RegWrite = 1'b1;
        c.Jump     = 1'b1;
      end
      default: c = '0;
    endcase
    if (rd == '0) c.RegWrite = 1'b0;
    return c;
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate decoder (I/S/B/U/J), sign-extended to XLEN.
// Shared between decode and the fetch-stage branch predictor.
module imm_gen
  import core_pkg::*;
(
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    imm = '0;
    case (instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR:
        imm = {{20{instr[31]}}, instr[31:20]};
      OP_STORE:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {instr[31:12], 12'b0};
      OP_JAL:
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I ID stage: register read addressing, WB bypass, control/immediate decode,
// load-use stall and the ID/EX pipeline register.
module decode_stage #(
  parameter int XLEN       = core_pkg::XLEN,
  parameter int REG_ADDR_W = core_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_valid,
  input  logic [31:0]           if_instr,
  input  logic [XLEN-1:0]       if_pc,
  output logic                  id_ready,
  output logic [REG_ADDR_W-1:0] Rs1,
  output logic [REG_ADDR_W-1:0] Rs2,
  input  logic [XLEN-1:0]       Read_data1,
  input  logic [XLEN-1:0]       Read_data2,
  input  logic                  wb_RegWrite,
  input  logic [REG_ADDR_W-1:0] wb_Rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  flush,
  input  logic                  ex_ready,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_rs1_val,
  output logic [XLEN-1:0]       ex_rs2_val,
  output logic [XLEN-1:0]       ex_imm,
  output logic [REG_ADDR_W-1:0] ex_Rd,
  output logic [6:0]            ex_opcode,
  output logic [3:0]            ex_funct,
  output logic                  ex_RegWrite,
  output logic                  ex_MemRead,
  output logic                  ex_MemWrite,
  output logic                  ex_Branch,
  output logic                  ex_Jump
);
  import core_pkg::*;

  logic [6:0]            opcode;
  logic [REG_ADDR_W-1:0] rd;
  logic [XLEN-1:0]       imm;
  logic [XLEN-1:0]       rs1_val;
  logic [XLEN-1:0]       rs2_val;
  ctrl_t                 ctrl;
  ctrl_t                 ex_ctrl;
  logic                  hz;
  logic                  adv;

  assign opcode = if_instr[6:0];
  assign rd     = if_instr[11:7];
  assign Rs1    = if_instr[19:15];
  assign Rs2    = if_instr[24:20];
  assign ctrl   = decode_ctrl(opcode, rd);

  imm_gen u_imm_gen (
    .instr (if_instr),
    .imm   (imm)
  );

  // x0 reads as zero; otherwise a same-cycle WB write to the source wins over the regfile.
  always_comb begin
    rs1_val = Read_data1;
    rs2_val = Read_data2;
    if (Rs1 == '0)
      rs1_val = '0;
    else if (wb_RegWrite && (wb_Rd == Rs1))
      rs1_val = wb_data;
    if (Rs2 == '0)
      rs2_val = '0;
    else if (wb_RegWrite && (wb_Rd == Rs2))
      rs2_val = wb_data;
  end

  assign hz = ex_valid && ex_ctrl.MemRead && (ex_Rd != '0) && if_valid &&
              ((ex_Rd == Rs1) || ((ex_Rd == Rs2) && uses_rs2(opcode)));
  assign adv      = ex_ready || !ex_valid;
  assign id_ready = adv && !hz;

  // Flush and bubbles only kill validity and control; data fields are left as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_pc      <= '0;
      ex_rs1_val <= '0;
      ex_rs2_val <= '0;
      ex_imm     <= '0;
      ex_Rd      <= '0;
      ex_opcode  <= '0;
      ex_funct   <= '0;
    end else if (flush || (adv && hz)) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
    end else if (adv) begin
      ex_valid   <= if_valid;
      ex_ctrl    <= if_valid ? ctrl : '0;
      ex_pc      <= if_pc;
      ex_rs1_val <= rs1_val;
      ex_rs2_val <= rs2_val;
      ex_imm     <= imm;
      ex_Rd      <= rd;
      ex_opcode  <= opcode;
      ex_funct   <= {if_instr[30], if_instr[14:12]};
    end
  end

  assign ex_RegWrite = ex_ctrl.RegWrite;
  assign ex_MemRead  = ex_ctrl.MemRead;
  assign ex_MemWrite = ex_ctrl.MemWrite;
  assign ex_Branch   = ex_ctrl.Branch;
  assign ex_Jump     = ex_ctrl.Jump;

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage with hand-computed expectations.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic [4:0]  Rs1, Rs2;
  logic [31:0] Read_data1, Read_data2;
  logic        wb_RegWrite;
  logic [4:0]  wb_Rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_Rd;
  logic [6:0]  ex_opcode;
  logic [3:0]  ex_funct;
  logic        ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_Jump;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .id_ready    (id_ready),
    .Rs1         (Rs1),
    .Rs2         (Rs2),
    .Read_data1  (Read_data1),
    .Read_data2  (Read_data2),
    .wb_RegWrite (wb_RegWrite),
    .wb_Rd       (wb_Rd),
    .wb_data     (wb_data),
    .flush       (flush),
    .ex_ready    (ex_ready),
    .ex_valid    (ex_valid),
    .ex_pc       (ex_pc),
    .ex_rs1_val  (ex_rs1_val),
    .ex_rs2_val  (ex_rs2_val),
    .ex_imm      (ex_imm),
    .ex_Rd       (ex_Rd),
    .ex_opcode   (ex_opcode),
    .ex_funct    (ex_funct),
    .ex_RegWrite (ex_RegWrite),
    .ex_MemRead  (ex_MemRead),
    .ex_MemWrite (ex_MemWrite),
    .ex_Branch   (ex_Branch),
    .ex_Jump     (ex_Jump)
  );

  function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] s_ins(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] b_ins(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] j_ins(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_valid = 1'b0; if_instr = r_ins(7'h00, 5'd11, 5'd10, 3'd0, 5'd3);
    if_pc = 32'h0; Read_data1 = 32'd5; Read_data2 = 32'd6;
    wb_RegWrite = 1'b0; wb_Rd = 5'd0; wb_data = 32'h0; flush = 1'b0; ex_ready = 1'b1;
    #12;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%0h exp=0", ex_valid); end
    total++; if ({ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_Jump} !== 5'b0) begin bad++; $display("[TB] FAIL reset_ctrl got=%b exp=00000", {ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_Jump}); end
    total++; if ({ex_pc, ex_imm, ex_rs1_val} !== 96'h0) begin bad++; $display("[TB] FAIL reset_data got=%h exp=0", {ex_pc, ex_imm, ex_rs1_val}); end
    total++; if (id_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_id_ready got=%0h exp=1", id_ready); end
    total++; if ({Rs1, Rs2} !== {5'd10, 5'd11}) begin bad++; $display("[TB] FAIL reset_rs_addr got=%0d,%0d exp=10,11", Rs1, Rs2); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    if_valid = 1'b1; if_instr = r_ins(7'h00, 5'd11, 5'd10, 3'd0, 5'd3); if_pc = 32'h100;
    Read_data1 = 32'd5; Read_data2 = 32'd6;
    tick();
    total++; if (ex_valid !== 1'b1) begin bad++; $display("[TB] FAIL add_valid got=%0h exp=1", ex_valid); end
    total++; if ({ex_rs1_val, ex_rs2_val} !== {32'd5, 32'd6}) begin bad++; $display("[TB] FAIL add_ops got=%0h,%0h exp=5,6", ex_rs1_val, ex_rs2_val); end
    total++; if ({ex_Rd, ex_RegWrite, ex_MemRead} !== {5'd3, 1'b1, 1'b0}) begin bad++; $display("[TB] FAIL add_rd_ctrl got=%0d,%b%b exp=3,10", ex_Rd, ex_RegWrite, ex_MemRead); end
    total++; if ({ex_pc, ex_opcode, ex_funct, ex_imm} !== {32'h100, 7'h33, 4'h0, 32'h0}) begin bad++; $display("[TB] FAIL add_fields got=%h,%h,%h,%h exp=100,33,0,0", ex_pc, ex_opcode, ex_funct, ex_imm); end
    if_instr = r_ins(7'h20, 5'd11, 5'd10, 3'd0, 5'd3);
    tick();
    total++; if (ex_funct !== 4'b1000) begin bad++; $display("[TB] FAIL sub_funct got=%b exp=1000", ex_funct); end
    if_instr = r_ins(7'h00, 5'd11, 5'd10, 3'd0, 5'd3);
    wb_RegWrite = 1'b1; wb_Rd = 5'd10; wb_data = 32'h1234;
    tick();
    total++; if ({ex_rs1_val, ex_rs2_val} !== {32'h1234, 32'd6}) begin bad++; $display("[TB] FAIL bypass_rs1 got=%h,%h exp=1234,6", ex_rs1_val, ex_rs2_val); end
    wb_Rd = 5'd11;
    tick();
    total++; if ({ex_rs1_val, ex_rs2_val} !== {32'd5, 32'h1234}) begin bad++; $display("[TB] FAIL bypass_rs2 got=%h,%h exp=5,1234", ex_rs1_val, ex_rs2_val); end
    wb_Rd = 5'd0;
    tick();
    total++; if (ex_rs1_val !== 32'd5) begin bad++; $display("[TB] FAIL bypass_x0_dest got=%h exp=5", ex_rs1_val); end
    wb_RegWrite = 1'b0; wb_Rd = 5'd10;
    tick();
    total++; if (ex_rs1_val !== 32'd5) begin bad++; $display("[TB] FAIL bypass_no_write got=%h exp=5", ex_rs1_val); end
  endtask

  task automatic test_load_use();
    if_valid = 1'b1; if_instr = i_ins(12'd4, 5'd2, 3'd2, 5'd5, 7'b0000011); if_pc = 32'h200;
    tick();
    total++; if ({ex_valid, ex_MemRead, ex_RegWrite, ex_Rd, ex_imm} !== {3'b111, 5'd5, 32'd4}) begin bad++; $display("[TB] FAIL lw_latch got=%b%b%b,%0d,%h exp=111,5,4", ex_valid, ex_MemRead, ex_RegWrite, ex_Rd, ex_imm); end
    if_instr = r_ins(7'h00, 5'd1, 5'd5, 3'd0, 5'd6); if_pc = 32'h204;
    Read_data1 = 32'h0; Read_data2 = 32'h77;
    wb_RegWrite = 1'b1; wb_Rd = 5'd5; wb_data = 32'hAAAA;
    #1;
    total++; if (id_ready !== 1'b0) begin bad++; $display("[TB] FAIL lu_stall_ready got=%0h exp=0", id_ready); end
    tick();
    total++; if ({ex_valid, ex_RegWrite, ex_MemRead} !== 3'b000) begin bad++; $display("[TB] FAIL lu_bubble got=%b exp=000", {ex_valid, ex_RegWrite, ex_MemRead}); end
    total++; if (id_ready !== 1'b1) begin bad++; $display("[TB] FAIL lu_retry_ready got=%0h exp=1", id_ready); end
    wb_data = 32'hBEEF;
    tick();
    total++; if ({ex_valid, ex_Rd, ex_pc} !== {1'b1, 5'd6, 32'h204}) begin bad++; $display("[TB] FAIL lu_retry got=%0h,%0d,%h exp=1,6,204", ex_valid, ex_Rd, ex_pc); end
    total++; if ({ex_rs1_val, ex_rs2_val} !== {32'hBEEF, 32'h77}) begin bad++; $display("[TB] FAIL lu_retry_bypass got=%h,%h exp=beef,77", ex_rs1_val, ex_rs2_val); end
    wb_RegWrite = 1'b0;
    // rs2 hazard on a store, then an I-type whose imm field aliases rs2
    if_instr = i_ins(12'd4, 5'd2, 3'd2, 5'd5, 7'b0000011);
    tick();
    if_instr = s_ins(12'd0, 5'd5, 5'd3, 3'd2);
    #1;
    total++; if (id_ready !== 1'b0) begin bad++; $display("[TB] FAIL lu_rs2_store got=%0h exp=0", id_ready); end
    if_instr = i_ins(12'd5, 5'd1, 3'd0, 5'd7, 7'b0010011);
    #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("[TB] FAIL lu_itype_no_rs2 got=%0h exp=1", id_ready); end
    tick();
    total++; if ({ex_valid, ex_Rd, ex_MemRead, ex_imm} !== {1'b1, 5'd7, 1'b0, 32'd5}) begin bad++; $display("[TB] FAIL addi_after_lw got=%0h,%0d,%0h,%h exp=1,7,0,5", ex_valid, ex_Rd, ex_MemRead, ex_imm); end
    if_instr = i_ins(12'd0, 5'd2, 3'd2, 5'd0, 7'b0000011);
    tick();
    total++; if ({ex_MemRead, ex_RegWrite} !== 2'b10) begin bad++; $display("[TB] FAIL lw_x0_ctrl got=%b exp=10", {ex_MemRead, ex_RegWrite}); end
    if_instr = r_ins(7'h00, 5'd1, 5'd0, 3'd0, 5'd6);
    #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("[TB] FAIL lw_x0_no_hazard got=%0h exp=1", id_ready); end
    tick();
  endtask

  task automatic test_back_pressure();
    if_valid = 1'b1; if_instr = r_ins(7'h00, 5'd11, 5'd10, 3'd0, 5'd3); if_pc = 32'h300;
    Read_data1 = 32'd5; Read_data2 = 32'd6;
    tick();
    ex_ready = 1'b0;
    if_instr = i_ins(12'd7, 5'd1, 3'd0, 5'd8, 7'b0010011); if_pc = 32'h304;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (id_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_ready[%0d] got=%0h exp=0", i, id_ready); end
      tick();
      total++; if ({ex_valid, ex_Rd, ex_pc, ex_RegWrite, ex_rs1_val} !== {1'b1, 5'd3, 32'h300, 1'b1, 32'd5}) begin bad++; $display("[TB] FAIL bp_hold[%0d] got=%0h,%0d,%h,%0h,%h exp=1,3,300,1,5", i, ex_valid, ex_Rd, ex_pc, ex_RegWrite, ex_rs1_val); end
    end
    ex_ready = 1'b1;
    #1;
    total++; if (id_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_release_ready got=%0h exp=1", id_ready); end
    tick();
    total++; if ({ex_valid, ex_Rd, ex_imm, ex_pc} !== {1'b1, 5'd8, 32'd7, 32'h304}) begin bad++; $display("[TB] FAIL bp_release_load got=%0h,%0d,%h,%h exp=1,8,7,304", ex_valid, ex_Rd, ex_imm, ex_pc); end
  endtask

  task automatic test_flush();
    if_valid = 1'b1; if_instr = i_ins(12'd4, 5'd2, 3'd2, 5'd5, 7'b0000011);
    tick();
    if_instr = r_ins(7'h00, 5'd1, 5'd5, 3'd0, 5'd6);
    flush = 1'b1;
    tick();
    total++; if ({ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_Jump} !== 6'b0) begin bad++; $display("[TB] FAIL flush_hazard got=%b exp=000000", {ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_Jump}); end
    flush = 1'b0; if_instr = r_ins(7'h00, 5'd11, 5'd10, 3'd0, 5'd3);
    tick();
    ex_ready = 1'b0; flush = 1'b1;
    tick();
    total++; if ({ex_valid, ex_RegWrite} !== 2'b00) begin bad++; $display("[TB] FAIL flush_over_hold got=%b exp=00", {ex_valid, ex_RegWrite}); end
    flush = 1'b0; ex_ready = 1'b1;
  endtask

  task automatic test_imm_x0();
    if_valid = 1'b1;
    if_instr = s_ins(12'hFF8, 5'd11, 5'd2, 3'd2);
    tick();
    total++; if ({ex_imm, ex_MemWrite, ex_RegWrite} !== {32'hFFFFFFF8, 2'b10}) begin bad++; $display("[TB] FAIL sw_imm got=%h,%b%b exp=fffffff8,10", ex_imm, ex_MemWrite, ex_RegWrite); end
    if_instr = b_ins(13'h1FF0, 5'd2, 5'd1, 3'd0);
    tick();
    total++; if ({ex_imm, ex_Branch, ex_RegWrite} !== {32'hFFFFFFF0, 2'b10}) begin bad++; $display("[TB] FAIL beq_imm got=%h,%b%b exp=fffffff0,10", ex_imm, ex_Branch, ex_RegWrite); end
    if_instr = j_ins(21'h000800, 5'd1);
    tick();
    total++; if ({ex_imm, ex_Jump, ex_RegWrite} !== {32'h800, 2'b11}) begin bad++; $display("[TB] FAIL jal_imm got=%h,%b%b exp=800,11", ex_imm, ex_Jump, ex_RegWrite); end
    if_instr = {20'h12345, 5'd7, 7'b0110111};
    tick();
    total++; if ({ex_imm, ex_RegWrite} !== {32'h12345000, 1'b1}) begin bad++; $display("[TB] FAIL lui_imm got=%h,%b exp=12345000,1", ex_imm, ex_RegWrite); end
    if_instr = i_ins(12'hFFC, 5'd1, 3'd0, 5'd0, 7'b1100111);
    tick();
    total++; if ({ex_imm, ex_Jump, ex_RegWrite} !== {32'hFFFFFFFC, 2'b10}) begin bad++; $display("[TB] FAIL jalr_x0 got=%h,%b%b exp=fffffffc,10", ex_imm, ex_Jump, ex_RegWrite); end
    if_instr = 32'h0FF0000F;
    tick();
    total++; if ({ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_Jump, ex_imm} !== {6'b100000, 32'h0}) begin bad++; $display("[TB] FAIL illegal_op got=%b,%h exp=100000,0", {ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_Jump}, ex_imm); end
    Read_data1 = 32'h55;
    if_instr = i_ins(12'd1, 5'd0, 3'd0, 5'd0, 7'b0010011);
    tick();
    total++; if ({ex_RegWrite, ex_rs1_val, ex_imm} !== {1'b0, 32'h0, 32'd1}) begin bad++; $display("[TB] FAIL addi_x0 got=%b,%h,%h exp=0,0,1", ex_RegWrite, ex_rs1_val, ex_imm); end
    if_valid = 1'b0;
    if_instr = r_ins(7'h00, 5'd11, 5'd10, 3'd0, 5'd3);
    tick();
    total++; if ({ex_valid, ex_RegWrite} !== 2'b00) begin bad++; $display("[TB] FAIL invalid_if got=%b exp=00", {ex_valid, ex_RegWrite}); end
  endtask

  task automatic test_async_reset();
    if_valid = 1'b1; if_instr = i_ins(12'd4, 5'd2, 3'd2, 5'd5, 7'b0000011);
    tick();
    if_instr = r_ins(7'h00, 5'd1, 5'd5, 3'd0, 5'd6);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if ({ex_valid, ex_MemRead, ex_RegWrite, ex_Rd} !== {3'b000, 5'd0}) begin bad++; $display("[TB] FAIL async_reset got=%b,%0d exp=000,0", {ex_valid, ex_MemRead, ex_RegWrite}, ex_Rd); end
    total++; if (id_ready !== 1'b1) begin bad++; $display("[TB] FAIL async_reset_ready got=%0h exp=1", id_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    if_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_load_use();
    test_back_pressure();
    test_flush();
    test_imm_x0();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage of the pipelined RV32I core. Takes the fetched instruction, drives the register-file read addresses, and decodes control and immediate.
- Applies WB-to-ID bypass and holds everything in the ID/EX pipeline register for the execute stage.
- Detects load-use hazards, stalls fetch, inserts a bubble, and honours flush from branch resolution.

Parameters:
- XLEN, 32, datapath and register width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  pipeline clock; only clock domain.
- rst_n  in  1  asynchronous active-low reset.
- if_valid  in  1  IF/ID holds a valid instruction.
- if_instr  in  32  instruction word.
- if_pc  in  32  PC of if_instr.
- id_ready  out  1  ID accepts if_instr this cycle; low = IF must hold.
- Rs1  out  5  register-file read address 1 (instr[19:15]).
- Rs2  out  5  register-file read address 2 (instr[24:20]).
- Read_data1  in  32  register-file combinational read data 1.
- Read_data2  in  32  register-file combinational read data 2.
- wb_RegWrite  in  1  WB stage writes this cycle.
- wb_Rd  in  5  WB destination.
- wb_data  in  32  WB write data.
- flush  in  1  kill the instruction in ID and the one being loaded into EX.
- ex_ready  in  1  EX consumes the ID/EX contents this cycle.
- ex_valid  out  1  ID/EX holds a valid instruction.
- ex_pc  out  32  latched PC.
- ex_rs1_val, ex_rs2_val  out  32 each  latched operands after bypass.
- ex_imm  out  32  sign-extended immediate.
- ex_Rd  out  5  destination register.
- ex_opcode  out  7  latched opcode.
- ex_funct  out  4  {instr[30], funct3}.
- ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_Jump  out  1 each  control bits.

Behaviour:
- Reset (async, rst_n=0): every ex_* output is 0, ex_valid=0, no pending bubble. id_ready follows its combinational equation.
- Rs1 and Rs2 are combinational from if_instr fields, independent of if_valid.
- Bypass: if wb_RegWrite and wb_Rd!=0 and wb_Rd==Rs1, the operand is wb_data, else Read_data1. Same rule for Rs2.
- x0 operands are always 0, regardless of Read_data.
- Immediate formats follow RV32I I/S/B/U/J; unknown or R-type gives 0.
- Control by opcode:
  - 0110011 R: RegWrite.
  - 0010011 I-ALU: RegWrite.
  - 0000011 LOAD: RegWrite, MemRead.
  - 0100011 STORE: MemWrite.
  - 1100011 BRANCH: Branch.
  - 0110111 LUI: RegWrite.
  - 1101111 JAL: RegWrite, Jump.
  - 1100111 JALR: RegWrite, Jump.
  - Any other opcode: all control bits 0, but ex_valid is still set so EX can raise an illegal-instruction trap.
- RegWrite is forced to 0 when Rd==0.
- Load-use hazard: hz = ex_valid & ex_MemRead & ex_Rd!=0 & if_valid & (ex_Rd==Rs1 | (ex_Rd==Rs2 & the opcode uses rs2)).
- Advance: adv = ex_ready | ~ex_valid.
- id_ready = adv & ~hz.
- On each rising edge:
  - flush: ex_valid<=0 and the control bits <=0; data fields are don't-care. Flush has priority over all other conditions.
  - else adv & hz: insert a bubble (ex_valid<=0, control bits 0). IF holds, and the instruction re-decodes next cycle, when the load has moved to MEM and the hazard clears.
  - else adv: load all ex_* fields, with ex_valid<=if_valid.
  - else (~adv): hold all ex_* fields unchanged.
- Latency: one cycle from if_instr acceptance to ex_valid.
- Simultaneous wb write to the same Rd and hazard: the hazard wins and the bubble is inserted. The bypass value is re-evaluated on retry.
- Reset asserted mid-stall clears ex_valid immediately; no state survives.

Decomposition:
- Package core_pkg holds:
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_JAL, OP_JALR);
  - XLEN and REG_ADDR_W;
  - the ctrl_t struct {RegWrite, MemRead, MemWrite, Branch, Jump}.
- Sub-module imm_gen: a combinational instruction-to-immediate decoder, reused later by the fetch-stage branch predictor.

Test Plan:
- Reset then add x3,x10,x11 (Read_data1=5, Read_data2=6) -> next cycle ex_valid=1, ex_rs1_val=5, ex_rs2_val=6, ex_Rd=3, ex_RegWrite=1.
- Bypass: same add with wb_RegWrite=1, wb_Rd=10, wb_data=0x1234 -> ex_rs1_val=0x1234. Repeat with wb_Rd=0 -> ex_rs1_val=5.
- Load-use: lw x5,4(x2) then add x6,x5,x1 -> cycle 2: id_ready=0 and a bubble (ex_valid=0); cycle 3: add latched with ex_Rd=6.
- Back-pressure: ex_ready=0 for 3 cycles with a valid ex_* -> all outputs stable and id_ready=0. Release -> the next instruction loads.
- Flush coincident with a valid lw and hz=1 -> ex_valid=0 next cycle and all control bits 0.
- Immediates and x0: sw x11,-8(x2) -> ex_imm=0xFFFFFFF8, ex_MemWrite=1, ex_RegWrite=0. addi x0,x0,1 -> ex_RegWrite=0, ex_rs1_val=0. Async rst_n low mid-stream -> ex_valid=0 without waiting for a clock edge.
